// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   General-purpose register file for a single-cycle RV32 core.
//   2**ADDR_WIDTH entries of DATA_WIDTH bits, one synchronous write port and
//   one combinational (zero-latency) read port. With ZERO_REG=1 entry 0 is
//   hardwired to zero (RISC-V x0): writes to it are dropped and reads return 0.
//
// Ports
//   clk    in   1           clock; writes occur on the rising edge
//   rst    in   1           asynchronous active-low reset; clears every entry
//   wen    in   1           write enable, sampled at posedge clk
//   waddr  in   ADDR_WIDTH  write address
//   wdata  in   DATA_WIDTH  write data
//   raddr  in   ADDR_WIDTH  read address
//   rdata  out  DATA_WIDTH  read data, combinational from raddr and contents
// -----------------------------------------------------------------------------
module register_file #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_allow;
    logic                  rd_zero;

    // Writes to entry 0 are suppressed when it models x0.
    assign wr_allow = !(ZERO_REG && (waddr == '0));
    assign rd_zero  = ZERO_REG && (raddr == '0);

    // The explicit if (wen) keeps an X on wen from spilling into the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wen) begin
            if (wr_allow) begin
                mem_q[waddr] <= wdata;
            end
        end
    end

    // No write-to-read bypass: a same-address write shows up after the edge.
    assign rdata = rd_zero ? '0 : mem_q[raddr];

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Directed-vector bench for register_file. Each check pushes the expected
//   read value into a scoreboard queue and fires a probe event; a separate
//   monitor process pops the queue and compares against rdata.
// -----------------------------------------------------------------------------
module tb_register_file;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    typedef struct {
        string         name;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t sb_q[$];
    event probe_ev;
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;

    register_file #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ZERO_REG  (1'b1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .wen  (wen),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(rdata)
    );

    initial begin
        clk = 1'b0;
        forever #100 clk = ~clk;
    end

    // Monitor: one comparison per probe, expected value from the scoreboard.
    initial begin
        vec_t v;
        forever begin
            @(probe_ev);
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL probe_without_expectation: rdata=%h, required a queued vector", rdata);
            end else begin
                v = sb_q.pop_front();
                if (rdata !== v.exp) begin
                    n_err++;
                    $display("FAIL %s: raddr=%0d rdata=%h required=%h", v.name, v.addr, rdata, v.exp);
                end
            end
        end
    end

    // Issue one read vector; the spacing keeps raddr stable while the monitor samples.
    task automatic check(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        vec_t v;
        raddr = addr;
        v.name = name;
        v.addr = addr;
        v.exp  = exp;
        sb_q.push_back(v);
        #1;
        ->probe_ev;
        #1;
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            check(name, AW'(i), '0);
        end
    endtask

    // Single write cycle launched from a negedge; returns at the following negedge.
    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", 5'd3, '0);
        rst = 1'b1;

        // Test 1: asynchronous reset clears a written entry between edges.
        @(negedge clk);
        write(5'd5, 32'h0000_1234);
        check("wr5_before_reset", 5'd5, 32'h0000_1234);
        raddr = 5'd5;
        rst = 1'b0;
        check("reset_immediate_e5", 5'd5, '0);
        rst = 1'b1;
        @(negedge clk);
        sweep_zero("reset_sweep");

        // Test 2: basic write, neighbour untouched.
        @(negedge clk);
        write(5'd1, 32'h8000_0000);
        check("wr1_msb", 5'd1, 32'h8000_0000);
        check("e2_untouched", 5'd2, '0);

        // Test 3: x0 ignores writes.
        write(5'd0, 32'hDEAD_BEEF);
        check("x0_hardwired", 5'd0, '0);
        check("e1_after_x0_write", 5'd1, 32'h8000_0000);

        // Test 4: read-during-write on the same address, no bypass.
        write(5'd7, 32'd3);
        check("e7_old", 5'd7, 32'd3);
        wen   = 1'b1;
        waddr = 5'd7;
        wdata = 32'd9;
        check("rdw_before_edge", 5'd7, 32'd3);
        @(posedge clk);
        check("rdw_after_edge", 5'd7, 32'd9);
        @(negedge clk);
        wen = 1'b0;

        // Test 5: hold with wen=0, then write all-ones to the top entry.
        waddr = 5'd31;
        wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("e31_hold", 5'd31, '0);
        write(5'd31, 32'hFFFF_FFFF);
        check("e31_all_ones", 5'd31, 32'hFFFF_FFFF);
        check("e30_untouched", 5'd30, '0);

        // Test 6: reset dominates a write at a clock edge.
        rst   = 1'b0;
        wen   = 1'b1;
        waddr = 5'd10;
        wdata = 32'hAAAA_5555;
        @(negedge clk);
        sweep_zero("rst_blocks_write");
        rst = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        check("write_after_reset", 5'd10, 32'hAAAA_5555);
        check("e11_after_reset", 5'd11, '0);
        check("e7_cleared", 5'd7, '0);

        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!stim_done) begin
            n_err++;
            $display("FAIL stimulus_timeout: stim_done=%0d, required 1 within 200 cycles", stim_done);
        end
        #5;
        if (sb_q.size() != 0) begin
            n_err += sb_q.size();
            $display("FAIL scoreboard_drain: %0d vectors left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
